stream_sink_checker: RTL and testbench
======================================

Name: stream_sink_checker

Overview:
- Downstream consumer (sink) end of the team's valid/ready stream interface. It is the receiving counterpart to the stream sources and skid buffers on that interface.
- Drives `in_ready` with a selectable backpressure pattern and checks each accepted beat against an expected LFSR sequence.
- Counts beats and mismatches, and flags valid/ready protocol violations.
- Used as the sink in handshake-pipeline benches and as a built-in self-test sink on silicon.

Parameters:
- DATA_WIDTH, 8, width of the data bus and of the expected-data LFSR.
- LFSR_POLY, 8'hB8, Galois feedback mask. Width is DATA_WIDTH.
- CNT_WIDTH, 16, width of the beat count, error count and index registers.

Ports:
- clk  in  1  the single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; loads seed and beats and begins a run.
- seed  in  DATA_WIDTH  first expected data value.
- beats  in  CNT_WIDTH  number of beats to accept.
- ready_mode  in  2  0 = always ready, 1 = alternate, 2 = pseudo-random, 3 = never ready.
- in_valid  in  1  upstream valid.
- in_data  in  DATA_WIDTH  upstream data.
- in_ready  out  1  registered ready to upstream.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high; equals (err_cnt==0 && !proto_err).
- beat_cnt  out  CNT_WIDTH  beats accepted in the current or last run.
- err_cnt  out  CNT_WIDTH  data mismatches; saturates at all-ones.
- first_err_idx  out  CNT_WIDTH  beat index of the first mismatch; holds all-ones if there has been none.
- proto_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=0; busy=0; done=0; pass=0; beat_cnt=0; err_cnt=0; first_err_idx=all-ones; proto_err=0; expected=0; ready-LFSR=16'hACE1.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE + start: load expected=seed, remaining=beats, clear counters and flags, first_err_idx=all-ones.
    - If beats==0, go to DONE with pass=1.
    - Otherwise go to RUN.
  - RUN + start: restart with the same re-initialisation. This is the only way out of mode 3 other than reset.
  - RUN + final handshake (remaining==1): go to DONE.
  - DONE holds until start.
- Handshake: a beat is accepted only when in_valid && in_ready on the same edge. in_ready is a flop and never combinationally depends on in_valid.
- in_ready generation:
  - in_ready is computed from the next state and is 0 whenever the next state is not RUN. It is therefore 0 in the cycle after the final handshake.
  - Mode 0: 1 throughout RUN.
  - Mode 1: 1 in the first RUN cycle, then toggles every cycle.
  - Mode 2: bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every RUN cycle.
  - Mode 3: 0.
  - ready_mode is sampled every cycle; a mid-run change takes effect on the next edge.
- On each accepted beat:
  - Compare in_data with expected.
  - On mismatch: err_cnt+1 (saturating). If it is the first mismatch, first_err_idx=beat_cnt.
  - expected advances to (expected>>1) ^ (expected[0] ? LFSR_POLY : 0). It advances on handshake only, never on stall.
  - beat_cnt+1 and remaining-1.
  - seed=0 yields an all-zero expected sequence, which is legal.
- Protocol check (RUN only):
  - If the previous cycle had in_valid=1 && in_ready=0, then this cycle must have in_valid=1 and in_data equal to the previous in_data.
  - Otherwise set proto_err. It stays set until start or rst.
- Counter widths: beat_cnt wraps only if beats exceeds 2^CNT_WIDTH-1, which cannot happen because beats is bounded by its width.
- Latency: start→busy is 1 cycle. Final handshake→done is 1 cycle.

Test Plan:
- Ordering check: rst pulse mid-RUN → all outputs return to their reset values on that edge asynchronously, and in_ready=0 before the next clk.
- Mode 0 clean run: seed=8'h01, beats=6, source sends 01,B8,5C,2E,17,B3 with valid held high → 6 handshakes on consecutive cycles; done=1 one cycle after the 6th; pass=1; beat_cnt=6; err_cnt=0.
- Single mismatch: same run with the 3rd beat=8'h5D → err_cnt=1; first_err_idx=2; pass=0; beats 4–6 still match (expected not resynced to bad data).
- Mode 1 stall hold: source holds 8'hB8 across a ready=0 cycle → no proto_err. Repeat, changing data to 8'h00 during the stall → proto_err=1 and pass=0 at done.
- beats=0 start → done=1 next cycle; pass=1; in_ready never asserted. Mode 3 with beats=4 → busy stays high and in_ready stays 0 for 100 cycles. A start pulse then restarts the run with fresh counters.
- Mode 2 random backpressure: 200 beats from seed=8'hA5 → pass=1; beat_cnt=200; no beat accepted while in_ready=0.

Source files
------------

// File: rtl/stream_sink_checker_if.sv
// Valid/ready stream bundle between a source (master) and a sink (slave).
//   in_valid : source has a beat on in_data
//   in_data  : beat payload, DATA_WIDTH bits
//   in_ready : sink will accept the beat on the next rising edge
interface stream_sink_checker_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/stream_sink_checker.sv
// Stream sink checker: consumes a valid/ready stream with a selectable
// backpressure pattern, checks each accepted beat against an LFSR sequence,
// counts beats and mismatches, and flags valid/ready protocol violations.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse: load seed/beats and (re)start a run
//   seed, beats       first expected value, number of beats to accept
//   ready_mode        0 always, 1 alternate, 2 pseudo-random, 3 never ready
//   s (slave)         in_valid / in_data in, registered in_ready out
//   busy, done, pass  run status; pass is meaningful while done is high
//   beat_cnt, err_cnt beats accepted, data mismatches (saturating)
//   first_err_idx     beat index of first mismatch, all-ones if none
//   proto_err         sticky valid/ready protocol violation
module stream_sink_checker #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(8'hB8),
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [CNT_WIDTH-1:0]  beats,
  input  logic [1:0]            ready_mode,
  stream_sink_checker_if.slave  s,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic                  proto_err
);

  localparam int unsigned          RL_WIDTH = 16;
  localparam logic [RL_WIDTH-1:0]  RL_SEED  = 16'hACE1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [CNT_WIDTH-1:0]  first_q, first_d;
  logic [RL_WIDTH-1:0]   rl_q, rl_d;
  logic                  proto_q, proto_d;
  logic                  stall_q, stall_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  assign s.in_ready    = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign beat_cnt      = beat_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;
  assign proto_err     = proto_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      pdata_q <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      first_q <= CNT_ONES;
      rl_q    <= RL_SEED;
      proto_q <= 1'b0;
      stall_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      pdata_q <= pdata_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      first_q <= first_d;
      rl_q    <= rl_d;
      proto_q <= proto_d;
      stall_q <= stall_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next state, beat checking, protocol check and ready generation
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    pdata_d = s.in_data;
    rem_d   = rem_q;
    beat_d  = beat_q;
    err_d   = err_q;
    first_d = first_q;
    rl_d    = rl_q;
    proto_d = proto_q;
    stall_d = 1'b0;
    ready_d = 1'b0;

    if (start) begin
      // Start wins in every state, including a run stuck in mode 3
      state_d = (beats == '0) ? DONE : RUN;
      exp_d   = seed;
      rem_d   = beats;
      beat_d  = '0;
      err_d   = '0;
      first_d = CNT_ONES;
      proto_d = 1'b0;
    end else if (state_q == RUN) begin
      // A stalled beat must be held unchanged until accepted
      if (stall_q && (!s.in_valid || (s.in_data != pdata_q))) begin
        proto_d = 1'b1;
      end
      if (s.in_valid && ready_q) begin
        if (s.in_data != exp_q) begin
          if (err_q != CNT_ONES) err_d = err_q + CNT_WIDTH'(1);
          if (err_q == '0) first_d = beat_q;
        end
        // Expected advances on handshakes only, never resyncs to bad data
        exp_d  = (exp_q >> 1) ^ (exp_q[0] ? LFSR_POLY : '0);
        beat_d = beat_q + CNT_WIDTH'(1);
        rem_d  = rem_q - CNT_WIDTH'(1);
        if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
      end
      stall_d = s.in_valid && !ready_q;
    end

    // Ready is derived from the next state so it drops right after the last beat
    if (state_d == RUN) begin
      rl_d = {rl_q[RL_WIDTH-2:0], rl_q[15] ^ rl_q[13] ^ rl_q[12] ^ rl_q[10]};
      case (ready_mode)
        2'd0:    ready_d = 1'b1;
        2'd1:    ready_d = (state_q != RUN || start) ? 1'b1 : !ready_q;
        2'd2:    ready_d = rl_d[0];
        default: ready_d = 1'b0;
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == '0) && !proto_d;
  end

endmodule

// File: tb/tb_stream_sink_checker.sv
// Bench for stream_sink_checker: table of directed runs, hand sequences for
// mode 3 / restart / mid-run reset, and randomized runs checked against a
// queue-based model of the expected sequence and handshake rules.
module tb_stream_sink_checker;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] seed;
  logic [CW-1:0] beats;
  logic [1:0]    ready_mode;
  logic          busy, done, pass, proto_err;
  logic [CW-1:0] beat_cnt, err_cnt, first_err_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_sink_checker_if #(.DATA_WIDTH(DW)) sif ();

  stream_sink_checker #(
    .DATA_WIDTH(DW), .LFSR_POLY(8'hB8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .beats(beats),
    .ready_mode(ready_mode), .s(sif.slave), .busy(busy), .done(done),
    .pass(pass), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .proto_err(proto_err)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  sd;
    logic [15:0] nb;
    int          cidx;
    logic [7:0]  cval;
    bit          glitch;
    bit          rv;
    bit          e_pass;
    int          e_beats;
    int          e_err;
    int          e_first;
    bit          e_proto;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] e);
    return {1'b0, e[7:1]} ^ (e[0] ? 8'hB8 : 8'h00);
  endfunction

  // One complete run with a well-behaved source (optionally corrupting data,
  // or changing data once during a stall), checked cycle by cycle.
  task automatic run(input logic [1:0] mode, input logic [7:0] sd, input logic [15:0] nb,
                     input int cidx, input logic [7:0] cval, input bit glitch,
                     input bit rv, input int cpct);
    logic [7:0] expq[$];
    logic [7:0] e, d, prev_data;
    int k, m_err, m_first, rcyc;
    bit m_proto, prev_stall, stall, hs, glitched, fin;

    e = sd;
    for (int i = 0; i < int'(nb); i++) begin
      expq.push_back(e);
      e = lfsr_next(e);
    end
    sif.in_valid = 1'b0;
    ready_mode = mode;
    seed = sd;
    beats = nb;
    start = 1'b1;
    step();
    start = 1'b0;

    if (nb == 16'd0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_pass", pass, 1);
      chk("zero_beats", beat_cnt, 0);
      for (int i = 0; i < 3; i++) begin
        chk("zero_ready", sif.in_ready, 0);
        step();
      end
      return;
    end

    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    k = 0; m_err = 0; m_first = 'hFFFF; rcyc = 0;
    m_proto = 0; prev_stall = 0; glitched = 0; fin = 0; prev_data = '0;

    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (mode == 2'd0) chk("ready_m0", sif.in_ready, 1);
      else if (mode == 2'd1) chk("ready_m1", sif.in_ready, 32'((rcyc % 2) == 0));

      if (!sif.in_valid) begin
        if (k < int'(nb) && (!rv || $urandom_range(0, 3) != 0)) begin
          d = expq[k];
          if (k == cidx) d = cval;
          else if (cpct > 0 && $urandom_range(0, 99) < cpct) d = d ^ 8'($urandom_range(1, 255));
          sif.in_valid = 1'b1;
          sif.in_data = d;
        end
      end else if (prev_stall && glitch && !glitched) begin
        glitched = 1;
        sif.in_data = (sif.in_data == 8'h00) ? 8'hFF : 8'h00;
      end

      if (prev_stall && (!sif.in_valid || sif.in_data != prev_data)) m_proto = 1;
      hs = sif.in_valid && sif.in_ready;
      stall = sif.in_valid && !sif.in_ready;
      d = sif.in_data;
      prev_data = sif.in_data;

      step();
      rcyc++;

      if (hs) begin
        if (d != expq[k]) begin
          if (m_err == 0) m_first = k;
          m_err++;
        end
        k++;
        sif.in_valid = 1'b0;
      end
      prev_stall = stall;
      chk("beat_cnt", beat_cnt, k);
      if (k == int'(nb)) begin
        fin = 1;
        chk("fin_done", done, 1);
        chk("fin_ready", sif.in_ready, 0);
        chk("fin_busy", busy, 0);
      end
    end
    chk("run_timeout", 32'(fin), 1);

    chk("m_pass", pass, 32'(m_err == 0 && !m_proto));
    chk("m_err", err_cnt, m_err);
    chk("m_first", first_err_idx, m_first);
    chk("m_proto", proto_err, 32'(m_proto));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, sif.in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_beat"}, beat_cnt, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_first"}, first_err_idx, 32'hFFFF);
    chk({tag, "_proto"}, proto_err, 0);
  endtask

  initial begin
    int bad;

    tbl[0] = '{2'd0, 8'h01, 16'd6,   -1, 8'h00, 0, 0, 1, 6,   0, 'hFFFF, 0};
    tbl[1] = '{2'd0, 8'h01, 16'd6,    2, 8'h5D, 0, 0, 0, 6,   1, 2,      0};
    tbl[2] = '{2'd1, 8'h01, 16'd6,   -1, 8'h00, 0, 0, 1, 6,   0, 'hFFFF, 0};
    tbl[3] = '{2'd1, 8'h01, 16'd6,   -1, 8'h00, 1, 0, 0, 6,   1, 1,      1};
    tbl[4] = '{2'd0, 8'h33, 16'd0,   -1, 8'h00, 0, 0, 1, 0,   0, 'hFFFF, 0};
    tbl[5] = '{2'd2, 8'hA5, 16'd200, -1, 8'h00, 0, 0, 1, 200, 0, 'hFFFF, 0};
    tbl[6] = '{2'd1, 8'h00, 16'd5,   -1, 8'h00, 0, 1, 1, 5,   0, 'hFFFF, 0};
    tbl[7] = '{2'd2, 8'h3C, 16'd20,   0, 8'h00, 0, 1, 0, 20,  1, 0,      0};

    rst = 1'b1; start = 1'b0; seed = '0; beats = '0; ready_mode = 2'd0;
    sif.in_valid = 1'b0; sif.in_data = '0;
    #12;
    chk_reset_vals("por");
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run(tbl[i].mode, tbl[i].sd, tbl[i].nb, tbl[i].cidx, tbl[i].cval,
          tbl[i].glitch, tbl[i].rv, 0);
      chk("tbl_pass", pass, 32'(tbl[i].e_pass));
      chk("tbl_beats", beat_cnt, tbl[i].e_beats);
      chk("tbl_err", err_cnt, tbl[i].e_err);
      chk("tbl_first", first_err_idx, tbl[i].e_first);
      chk("tbl_proto", proto_err, 32'(tbl[i].e_proto));
      chk("tbl_done", done, 1);
    end

    // Mode 3 never readies; source holds its beat, then a restart
    ready_mode = 2'd3; seed = 8'h01; beats = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    sif.in_valid = 1'b1; sif.in_data = 8'h01;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy || sif.in_ready || proto_err || done) bad++;
      step();
    end
    chk("m3_stuck_bad", bad, 0);
    chk("m3_beats", beat_cnt, 0);
    run(2'd0, 8'h5A, 16'd5, -1, 8'h00, 0, 0, 0);
    chk("restart_beats", beat_cnt, 5);
    chk("restart_pass", pass, 1);

    // Randomized runs against the model
    for (int r = 0; r < 12; r++) begin
      run(2'($urandom_range(0, 2)), 8'($urandom), 16'($urandom_range(1, 30)), -1, 8'h00,
          1'($urandom_range(0, 1)), 1, 10);
    end

    // Asynchronous reset in the middle of a run
    ready_mode = 2'd0; seed = 8'h01; beats = 16'd10; start = 1'b1;
    step();
    start = 1'b0;
    sif.in_valid = 1'b1; sif.in_data = 8'h77;
    step();
    step();
    chk("pre_rst_beats", beat_cnt, 2);
    chk("pre_rst_err", err_cnt, 2);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    step();
    rst = 1'b0;
    sif.in_valid = 1'b0;
    step();
    chk("post_rst_ready", sif.in_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
